// File: rtl/cpld_ram_arbiter.sv
// Expansion SRAM arbiter: the CPC bus owns the SRAM by default and host DMA
// accesses are slotted into idle bus cycles. READY stalls the Z80 only on collision.
module cpld_ram_arbiter #(
    parameter int STROBE_CYCLES = 2,
    parameter int IDLE_MIN      = 1,
    parameter int STARVE_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        mreq_b,
    input  logic        rd_b,
    input  logic        wr_b,
    input  logic        cpc_ramcs_b,
    input  logic [4:0]  cpc_ramadrhi,
    input  logic [13:0] cpc_adr,
    output logic        ready,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [18:0] host_adr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        starved,
    output logic [18:0] sram_adr,
    output logic        sram_cs_b,
    output logic        sram_oe_b,
    output logic        sram_we_b,
    input  logic [7:0]  sram_din,
    output logic [7:0]  sram_dout,
    output logic        sram_dout_en
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HSETUP  = 2'd1,
        ST_HSTROBE = 2'd2,
        ST_HHOLD   = 2'd3
    } state_t;

    localparam logic [2:0] IDLE_MIN_C    = 3'(IDLE_MIN);
    localparam logic [2:0] STROBE_LAST_C = 3'(STROBE_CYCLES - 1);
    localparam logic [7:0] STARVE_LIM_C  = 8'(STARVE_LIMIT);

    state_t      state_r;
    logic [2:0]  strobe_cnt_r;
    logic [2:0]  idle_cnt_r;
    logic [7:0]  starve_cnt_r;
    logic        starved_r;
    logic        host_ack_r;
    logic [7:0]  host_rdata_r;
    logic        lat_wr_r;
    logic [18:0] lat_adr_r;
    logic [7:0]  lat_wdata_r;

    logic        grant_s;
    logic        starve_inc_s;
    logic [7:0]  starve_next_s;
    logic        cs_pass_s;

    // Grant and starvation bookkeeping decisions for the current cycle
    always_comb begin
        grant_s       = (state_r == ST_IDLE) && host_req && mreq_b && (idle_cnt_r >= IDLE_MIN_C);
        starve_inc_s  = (state_r == ST_IDLE) && host_req && !grant_s;
        starve_next_s = (starve_cnt_r == 8'hFF) ? 8'hFF : (starve_cnt_r + 8'd1);
    end

    // Consecutive bus-idle cycle counter, saturating at IDLE_MIN
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            idle_cnt_r <= 3'd0;
        end else if (!mreq_b) begin
            idle_cnt_r <= 3'd0;
        end else if (idle_cnt_r < IDLE_MIN_C) begin
            idle_cnt_r <= idle_cnt_r + 3'd1;
        end
    end

    // Starvation counter and sticky starved flag
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            starve_cnt_r <= 8'd0;
            starved_r    <= 1'b0;
        end else if (grant_s) begin
            starve_cnt_r <= 8'd0;
        end else if (starve_inc_s) begin
            starve_cnt_r <= starve_next_s;
            if (starve_next_s >= STARVE_LIM_C) begin
                starved_r <= 1'b1;
            end
        end
    end

    // Host access sequencer: setup, strobe, hold, with completion pulse and read capture
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_r      <= ST_IDLE;
            strobe_cnt_r <= 3'd0;
            host_ack_r   <= 1'b0;
            host_rdata_r <= 8'd0;
            lat_wr_r     <= 1'b0;
            lat_adr_r    <= 19'd0;
            lat_wdata_r  <= 8'd0;
        end else begin
            host_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        lat_wr_r    <= host_wr;
                        lat_adr_r   <= host_adr;
                        lat_wdata_r <= host_wdata;
                        state_r     <= ST_HSETUP;
                    end
                end
                ST_HSETUP: begin
                    strobe_cnt_r <= 3'd0;
                    state_r      <= ST_HSTROBE;
                end
                ST_HSTROBE: begin
                    if (strobe_cnt_r == STROBE_LAST_C) begin
                        state_r    <= ST_HHOLD;
                        host_ack_r <= 1'b1;
                        if (!lat_wr_r) begin
                            host_rdata_r <= sram_din;
                        end
                    end else begin
                        strobe_cnt_r <= strobe_cnt_r + 3'd1;
                    end
                end
                ST_HHOLD: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cs_pass_s = cpc_ramcs_b | mreq_b;

    // SRAM pin mux: CPC pass-through in IDLE, latched host access otherwise
    always_comb begin
        sram_adr     = {cpc_ramadrhi, cpc_adr};
        sram_cs_b    = cs_pass_s;
        sram_oe_b    = rd_b | cs_pass_s;
        sram_we_b    = wr_b | cs_pass_s;
        sram_dout_en = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sram_dout_en = 1'b0;
            end
            ST_HSETUP, ST_HHOLD: begin
                sram_adr     = lat_adr_r;
                sram_cs_b    = 1'b0;
                sram_oe_b    = 1'b1;
                sram_we_b    = 1'b1;
                sram_dout_en = lat_wr_r;
            end
            ST_HSTROBE: begin
                sram_adr     = lat_adr_r;
                sram_cs_b    = 1'b0;
                sram_oe_b    = lat_wr_r;
                sram_we_b    = ~lat_wr_r;
                sram_dout_en = lat_wr_r;
            end
            default: begin
                sram_dout_en = 1'b0;
            end
        endcase
    end

    // Only expansion-RAM CPC cycles collide with a host access
    assign ready      = ~((state_r != ST_IDLE) & ~mreq_b & ~cpc_ramcs_b);
    assign host_ack   = host_ack_r;
    assign host_rdata = host_rdata_r;
    assign starved    = starved_r;
    assign sram_dout  = lat_wdata_r;

endmodule

// File: tb/tb_cpld_ram_arbiter.sv
// Self-checking bench for cpld_ram_arbiter: transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_cpld_ram_arbiter;

    localparam int S    = 2;
    localparam int IMIN = 1;
    localparam int SLIM = 255;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        mreq_b, rd_b, wr_b, cpc_ramcs_b;
    logic [4:0]  cpc_ramadrhi;
    logic [13:0] cpc_adr;
    logic        ready;
    logic        host_req, host_wr;
    logic [18:0] host_adr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        starved;
    logic [18:0] sram_adr;
    logic        sram_cs_b, sram_oe_b, sram_we_b;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic        sram_dout_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpld_ram_arbiter #(.STROBE_CYCLES(S), .IDLE_MIN(IMIN), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .reset_b(reset_b), .mreq_b(mreq_b), .rd_b(rd_b), .wr_b(wr_b),
        .cpc_ramcs_b(cpc_ramcs_b), .cpc_ramadrhi(cpc_ramadrhi), .cpc_adr(cpc_adr),
        .ready(ready), .host_req(host_req), .host_wr(host_wr), .host_adr(host_adr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .starved(starved), .sram_adr(sram_adr), .sram_cs_b(sram_cs_b),
        .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b), .sram_din(sram_din),
        .sram_dout(sram_dout), .sram_dout_en(sram_dout_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ph = cycles elapsed since the grant edge (0 = bus with CPC)
    int          ph = 0;
    bit          m_wr = 1'b0;
    logic [18:0] m_adr = 19'd0;
    logic [7:0]  m_wdata = 8'd0;
    logic [7:0]  m_rdata = 8'd0;
    int          m_idle = 0;
    int          m_wait = 0;
    bit          m_starved = 1'b0;
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            bit g;
            @(posedge clk);
            if (!reset_b) begin
                ph = 0; m_idle = 0; m_wait = 0; m_starved = 1'b0; m_rdata = 8'd0; m_valid = 1'b1;
            end else begin
                g = (ph == 0) && host_req && mreq_b && (m_idle >= IMIN);
                if (ph == S + 1 && !m_wr) m_rdata = sram_din;
                if (g) m_wait = 0;
                else if (ph == 0 && host_req) begin
                    if (m_wait < 255) m_wait++;
                    if (m_wait >= SLIM) m_starved = 1'b1;
                end
                if (g) begin
                    ph = 1; m_wr = host_wr; m_adr = host_adr; m_wdata = host_wdata;
                end else if (ph == S + 2) ph = 0;
                else if (ph > 0) ph++;
                m_idle = mreq_b ? ((m_idle < 1000) ? m_idle + 1 : m_idle) : 0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle
    initial begin
        forever begin
            logic [18:0] e_adr;
            logic e_cs, e_oe, e_we, e_en, e_ack, e_rdy;
            bit strobe;
            @(negedge clk);
            if (m_valid) begin
                e_rdy = !(ph != 0 && !mreq_b && !cpc_ramcs_b);
                if (ph == 0) begin
                    e_adr = {cpc_ramadrhi, cpc_adr};
                    e_cs  = cpc_ramcs_b | mreq_b;
                    e_oe  = rd_b | e_cs;
                    e_we  = wr_b | e_cs;
                    e_en  = 1'b0;
                    e_ack = 1'b0;
                end else begin
                    strobe = (ph >= 2) && (ph <= S + 1);
                    e_adr = m_adr;
                    e_cs  = 1'b0;
                    e_we  = !(strobe && m_wr);
                    e_oe  = !(strobe && !m_wr);
                    e_en  = m_wr;
                    e_ack = (ph == S + 2);
                end
                check("m_sram_adr", sram_adr, e_adr);
                check("m_cs_b", sram_cs_b, e_cs);
                check("m_oe_b", sram_oe_b, e_oe);
                check("m_we_b", sram_we_b, e_we);
                check("m_dout_en", sram_dout_en, e_en);
                check("m_host_ack", host_ack, e_ack);
                check("m_ready", ready, e_rdy);
                check("m_host_rdata", host_rdata, m_rdata);
                check("m_starved", starved, m_starved);
                if (e_en) check("m_sram_dout", sram_dout, m_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one host access from IDLE and observe it up to the ack (bounded)
    task automatic host_xfer(input bit wr, input logic [18:0] a, input logic [7:0] d,
                             output int lat, output int we_lo, output int oe_lo,
                             output logic [7:0] rd_at_ack, output logic [18:0] adr_st,
                             output logic [7:0] dout_st);
        host_wr = wr; host_adr = a; host_wdata = d; host_req = 1'b1;
        lat = 0; we_lo = 0; oe_lo = 0; rd_at_ack = 8'd0; adr_st = 19'd0; dout_st = 8'd0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!sram_we_b) begin we_lo++; adr_st = sram_adr; dout_st = sram_dout; end
            if (!sram_oe_b) begin oe_lo++; adr_st = sram_adr; end
            if (host_ack) begin lat = n; rd_at_ack = host_rdata; break; end
        end
        tick();
        host_req = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int seen;
        seen = 0;
        for (int n = 0; n < 60 && seen == 0; n++) begin
            @(negedge clk);
            if (host_ack) seen = 1;
        end
        check(name, seen, 1);
        tick();
        host_req = 1'b0;
    endtask

    initial begin
        int lat, we_lo, oe_lo;
        logic [7:0] rdv, doutv;
        logic [18:0] adrv;

        reset_b = 1'b0; mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1; cpc_ramcs_b = 1'b1;
        cpc_ramadrhi = 5'h00; cpc_adr = 14'h0000; host_req = 1'b0; host_wr = 1'b0;
        host_adr = 19'd0; host_wdata = 8'd0; sram_din = 8'h00;
        tick(); tick();
        @(negedge clk);
        check("reset_ready", ready, 1); check("reset_ack", host_ack, 0);
        check("reset_rdata", host_rdata, 0); check("reset_starved", starved, 0);
        check("reset_dout_en", sram_dout_en, 0);
        tick(); reset_b = 1'b1;
        tick(); tick();

        // Host write: 1 request cycle + 4 grant-to-ack cycles
        host_xfer(1'b1, 19'h7C123, 8'h5A, lat, we_lo, oe_lo, rdv, adrv, doutv);
        check("wr_latency", lat, 5);
        check("wr_we_low_cycles", we_lo, 2);
        check("wr_oe_low_cycles", oe_lo, 0);
        check("wr_adr", adrv, 19'h7C123);
        check("wr_dout", doutv, 8'h5A);
        tick();

        // Host read
        sram_din = 8'hA5;
        host_xfer(1'b0, 19'h00010, 8'h00, lat, we_lo, oe_lo, rdv, adrv, doutv);
        check("rd_latency", lat, 5);
        check("rd_data_at_ack", rdv, 8'hA5);
        check("rd_oe_low_cycles", oe_lo, 2);
        check("rd_we_low_cycles", we_lo, 0);
        check("rd_adr", adrv, 19'h00010);
        sram_din = 8'h00;
        tick();

        // CPC expansion access collides with host strobe: stalled until IDLE
        host_wr = 1'b1; host_adr = 19'h12345; host_wdata = 8'h3C; host_req = 1'b1;
        tick(); tick();
        mreq_b = 1'b0; cpc_ramcs_b = 1'b0; rd_b = 1'b0; cpc_ramadrhi = 5'h1F; cpc_adr = 14'h2AAA;
        @(negedge clk);
        check("stall_strobe_ready", ready, 0);
        check("stall_strobe_adr", sram_adr, 19'h12345);
        tick(); tick();
        @(negedge clk);
        check("stall_hold_ready", ready, 0);
        check("stall_hold_ack", host_ack, 1);
        tick(); host_req = 1'b0;
        @(negedge clk);
        check("cpc_resume_ready", ready, 1);
        check("cpc_resume_adr", sram_adr, 19'h7EAAA);
        check("cpc_resume_cs", sram_cs_b, 0);
        check("cpc_resume_oe", sram_oe_b, 0);
        tick(); mreq_b = 1'b1; rd_b = 1'b1; cpc_ramcs_b = 1'b1;
        tick();

        // Internal RAM/ROM access during host strobe is never stalled
        host_wr = 1'b0; host_adr = 19'h00200; host_req = 1'b1;
        tick(); tick();
        mreq_b = 1'b0; rd_b = 1'b0; cpc_ramcs_b = 1'b1;
        @(negedge clk);
        check("int_ram_ready", ready, 1);
        wait_ack("int_ram_ack");
        @(negedge clk);
        check("int_ram_cs_idle", sram_cs_b, 1);
        mreq_b = 1'b1; rd_b = 1'b1;
        tick(); tick();

        // Same-cycle CPC request and host request: CPC wins, grant after IDLE_MIN idle cycles
        mreq_b = 1'b0; cpc_ramcs_b = 1'b0; rd_b = 1'b0; cpc_ramadrhi = 5'h03; cpc_adr = 14'h0100;
        host_wr = 1'b0; host_adr = 19'h00ABC; host_req = 1'b1; sram_din = 8'h11;
        @(negedge clk);
        check("cpc_win_cs", sram_cs_b, 0);
        check("cpc_win_adr", sram_adr, 19'h0C100);
        tick(); mreq_b = 1'b1; rd_b = 1'b1; cpc_ramcs_b = 1'b1;
        @(negedge clk);
        check("no_grant_after_cpc", sram_cs_b, 1);
        tick();
        @(negedge clk);
        check("no_grant_idle_min", sram_cs_b, 1);
        tick();
        @(negedge clk);
        check("grant_setup_cs", sram_cs_b, 0);
        check("grant_setup_adr", sram_adr, 19'h00ABC);
        wait_ack("late_grant_ack");
        check("late_grant_rdata", host_rdata, 8'h11);
        tick();

        // Starvation: bus busy for 300 cycles with a pending host request
        mreq_b = 1'b0; cpc_ramcs_b = 1'b0; host_req = 1'b1; host_wr = 1'b1;
        host_adr = 19'h40000; host_wdata = 8'hC3;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 254) begin @(negedge clk); check("starved_at_254", starved, 0); end
            if (i == 255) begin @(negedge clk); check("starved_at_255", starved, 1); end
        end
        mreq_b = 1'b1; cpc_ramcs_b = 1'b1;
        wait_ack("starve_grant_ack");
        @(negedge clk);
        check("starved_sticky", starved, 1);
        tick();

        // Reset in the middle of a host write strobe
        host_wr = 1'b1; host_adr = 19'h7C123; host_wdata = 8'h5A; host_req = 1'b1;
        tick(); tick();
        reset_b = 1'b0; host_req = 1'b0;
        @(negedge clk);
        check("pre_reset_we", sram_we_b, 0);
        tick();
        @(negedge clk);
        check("rst_we", sram_we_b, 1);
        check("rst_dout_en", sram_dout_en, 0);
        check("rst_ack", host_ack, 0);
        check("rst_starved", starved, 0);
        check("rst_cs", sram_cs_b, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("rst_no_ack", host_ack, 0);
        end
        reset_b = 1'b1;
        tick(); tick();

        sram_din = 8'h6E;
        host_xfer(1'b0, 19'h55555, 8'h00, lat, we_lo, oe_lo, rdv, adrv, doutv);
        check("post_rst_latency", lat, 5);
        check("post_rst_rdata", rdv, 8'h6E);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
